burst_mem_responder: RTL and testbench

Responder end of the burst memory interface: accepts one burst read or write at a time from an arbiter's output port and services it as single-word accesses on a downstream word-wide memory port. It sits between the burst memory arbiter and an on-chip RAM or DDR word bridge. It generates the `wait_n`, `valid` and `burstDone` handshakes that the arbiter forwards to the granted client.

---
 rtl/burst_mem_pkg.sv | 22 ++
 rtl/burst_beat_counter.sv | 31 +++
 rtl/burst_mem_responder.sv | 150 +++++++++++++++
 tb/tb_burst_mem_responder.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_mem_pkg.sv
// burst_mem_pkg: shared state type, sizing helpers and
// default widths for the burst memory responder/arbiter slice.
package burst_mem_pkg;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int BURST_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } state_e;

  function automatic int bytes_of(input int dw);
    return dw / 8;
  endfunction

  function automatic int beat_w(input int bw);
    return bw + 1;
  endfunction
endpackage

// File: rtl/burst_beat_counter.sv
// burst_beat_counter: loadable beat counter that saturates
// at the burst length and flags the final beat.
module burst_beat_counter #(
  parameter int CW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic [CW-1:0] i_len,
  input  logic          i_inc,
  output logic [CW-1:0] o_count,
  output logic          o_last,
  output logic          o_full
);
  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_inc && !o_full) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_last  = (r_count == i_len - 1'b1);
  assign o_full  = (r_count >= i_len);
endmodule

// File: rtl/burst_mem_responder.sv
// burst_mem_responder: services one burst read or write at a
// time as single-word accesses on a downstream memory port.
module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_W,
  parameter int DATA_WIDTH  = DATA_W,
  parameter int BURST_WIDTH = BURST_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_in_rd,
  input  logic                    io_in_wr,
  input  logic [ADDR_WIDTH-1:0]   io_in_addr,
  input  logic [DATA_WIDTH/8-1:0] io_in_mask,
  input  logic [DATA_WIDTH-1:0]   io_in_din,
  input  logic [BURST_WIDTH-1:0]  io_in_burstLength,
  output logic [DATA_WIDTH-1:0]   io_in_dout,
  output logic                    io_in_wait_n,
  output logic                    io_in_valid,
  output logic                    io_in_burstDone,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_mask,
  output logic [DATA_WIDTH-1:0]   mem_din,
  input  logic                    mem_ack,
  input  logic                    mem_valid,
  input  logic [DATA_WIDTH-1:0]   mem_dout
);
  localparam int BYTES = bytes_of(DATA_WIDTH);
  localparam int CW    = beat_w(BURST_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(BYTES);

  state_e r_state, w_next;
  logic r_ready, r_buf_full, r_valid, r_done;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [CW-1:0]           r_len, w_len_in;
  logic [DATA_WIDTH-1:0]   r_buf_data, r_dout;
  logic [DATA_WIDTH/8-1:0] r_buf_mask;
  logic w_start, w_start_wr, w_take, w_adv;
  logic w_ret, w_done, w_wait_n;
  logic w_mem_rd, w_mem_wr;
  logic [CW-1:0] w_acc_cnt, w_beat_cnt, w_ret_cnt;
  logic w_acc_last, w_acc_full;
  logic w_beat_last, w_beat_full;
  logic w_ret_last, w_ret_full;
  logic w_unused;

  assign w_len_in = (io_in_burstLength == '0) ?
                    CW'(1) : CW'(io_in_burstLength);
  assign w_start    = (r_state == IDLE) && r_ready &&
                      (io_in_rd || io_in_wr);
  assign w_start_wr = w_start && io_in_wr;
  assign w_mem_wr   = (r_state == WRITE) && r_buf_full;
  assign w_mem_rd   = (r_state == READ) && !w_beat_full;
  assign w_adv      = (w_mem_wr || w_mem_rd) && mem_ack;
  assign w_take     = (r_state == WRITE) && io_in_wr && w_wait_n;
  assign w_ret      = (r_state == READ) && mem_valid;
  assign w_done     = (w_mem_wr && mem_ack && w_beat_last) ||
                      (w_ret && w_ret_last);

  // words taken from upstream; the first one comes with the request
  burst_beat_counter #(.CW(CW)) u_acc (
    .clk(clock), .rst_n(reset),
    .i_load(w_start), .i_load_val(w_start_wr ? CW'(1) : '0),
    .i_len(r_len), .i_inc(w_take),
    .o_count(w_acc_cnt), .o_last(w_acc_last), .o_full(w_acc_full)
  );

  // written (write) or issued (read): also the address beat index
  burst_beat_counter #(.CW(CW)) u_beat (
    .clk(clock), .rst_n(reset),
    .i_load(w_start), .i_load_val('0),
    .i_len(r_len), .i_inc(w_adv),
    .o_count(w_beat_cnt), .o_last(w_beat_last), .o_full(w_beat_full)
  );

  burst_beat_counter #(.CW(CW)) u_ret (
    .clk(clock), .rst_n(reset),
    .i_load(w_start), .i_load_val('0),
    .i_len(r_len), .i_inc(w_ret),
    .o_count(w_ret_cnt), .o_last(w_ret_last), .o_full(w_ret_full)
  );

  assign w_unused = ^{w_acc_cnt, w_acc_last, w_ret_cnt, w_ret_full};

  always_comb begin
    w_next   = r_state;
    w_wait_n = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_wait_n = r_ready;
        if (w_start_wr) w_next = WRITE;
        else if (w_start) w_next = READ;
      end
      WRITE: begin
        w_wait_n = !w_acc_full && (!r_buf_full || mem_ack);
        if (w_done) w_next = DONE;
      end
      READ: begin
        if (w_done) w_next = DONE;
      end
      DONE: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_ready    <= 1'b0;
      r_base     <= '0;
      r_len      <= '0;
      r_buf_data <= '0;
      r_buf_mask <= '0;
      r_buf_full <= 1'b0;
      r_valid    <= 1'b0;
      r_dout     <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= 1'b1;
      r_valid <= w_ret;
      r_done  <= w_done;
      if (w_ret) r_dout <= mem_dout;
      if (w_start) begin
        r_base <= io_in_addr;
        r_len  <= w_len_in;
      end
      // refill wins over drain when both land on the same edge
      if (w_start_wr || w_take) begin
        r_buf_data <= io_in_din;
        r_buf_mask <= io_in_mask;
        r_buf_full <= 1'b1;
      end else if (w_mem_wr && mem_ack) begin
        r_buf_full <= 1'b0;
      end
    end
  end

  assign mem_addr        = r_base + STRIDE * ADDR_WIDTH'(w_beat_cnt);
  assign mem_rd          = w_mem_rd;
  assign mem_wr          = w_mem_wr;
  assign mem_din         = r_buf_data;
  assign mem_mask        = r_buf_mask;
  assign io_in_wait_n    = w_wait_n;
  assign io_in_valid     = r_valid;
  assign io_in_dout      = r_dout;
  assign io_in_burstDone = r_done;
endmodule

// File: tb/tb_burst_mem_responder.sv
// tb_burst_mem_responder: directed plus randomized bursts against
// a RAM emulator and a byte-level reference memory model.
module tb_burst_mem_responder;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_in_rd = 1'b0;
  logic        io_in_wr = 1'b0;
  logic [31:0] io_in_addr = '0;
  logic [7:0]  io_in_mask = '0;
  logic [63:0] io_in_din = '0;
  logic [7:0]  io_in_burstLength = '0;
  logic [63:0] io_in_dout;
  logic        io_in_wait_n, io_in_valid, io_in_burstDone;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr;
  logic [7:0]  mem_mask;
  logic [63:0] mem_din;
  logic        mem_ack = 1'b0;
  logic        mem_valid = 1'b0;
  logic [63:0] mem_dout = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic rd; logic wr; logic [31:0] addr;
    logic [63:0] din; logic [7:0] mask;
  } acc_t;
  typedef struct { logic [63:0] data; int due; } ret_t;
  typedef struct { logic done; logic [63:0] data; } beat_t;

  acc_t  acc_q[$];
  ret_t  ret_q[$];
  beat_t beat_q[$];
  logic [63:0] emu_ram [logic [31:0]];
  logic [63:0] model_ram [logic [31:0]];
  logic [63:0] wd [16];
  logic [7:0]  wm [16];
  int ack_pct = 100;
  int lat_min = 1;
  int lat_max = 1;
  logic [31:0] stall_addr = '0;
  int stall_left = 0;
  int done_cnt = 0;

  burst_mem_responder dut (
    .clock(clock), .reset(reset),
    .io_in_rd(io_in_rd), .io_in_wr(io_in_wr),
    .io_in_addr(io_in_addr), .io_in_mask(io_in_mask),
    .io_in_din(io_in_din), .io_in_burstLength(io_in_burstLength),
    .io_in_dout(io_in_dout), .io_in_wait_n(io_in_wait_n),
    .io_in_valid(io_in_valid), .io_in_burstDone(io_in_burstDone),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_mask(mem_mask), .mem_din(mem_din),
    .mem_ack(mem_ack), .mem_valid(mem_valid), .mem_dout(mem_dout)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [63:0] init_val(input logic [31:0] a);
    return {a, a ^ 32'hA5A5_5A5A};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old,
      input logic [63:0] d, input logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++)
      if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] emu_rd(input logic [31:0] a);
    return emu_ram.exists(a) ? emu_ram[a] : init_val(a);
  endfunction

  function automatic logic [63:0] model_rd(input logic [31:0] a);
    return model_ram.exists(a) ? model_ram[a] : init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
      input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // RAM emulator: random acks, in-order returns after lat cycles
  always @(negedge clock) begin
    mem_ack   = 1'b0;
    mem_valid = 1'b0;
    if (!reset) begin
      ret_q.delete();
    end else begin
      if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
        mem_valid = 1'b1;
        mem_dout  = ret_q[0].data;
        void'(ret_q.pop_front());
      end
      if (mem_rd || mem_wr) begin
        if (mem_wr && mem_addr == stall_addr && stall_left > 0) begin
          stall_left--;
          #1 chk("stall_waitn", io_in_wait_n, 0);
        end else if ($urandom_range(99) < ack_pct) begin
          mem_ack = 1'b1;
          acc_q.push_back('{mem_rd, mem_wr, mem_addr, mem_din, mem_mask});
          if (mem_wr)
            emu_ram[mem_addr] = merge(emu_rd(mem_addr), mem_din, mem_mask);
          else
            ret_q.push_back('{emu_rd(mem_addr),
                              cyc + int'($urandom_range(lat_max, lat_min))});
        end
      end
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      if (io_in_valid) beat_q.push_back('{io_in_burstDone, io_in_dout});
      if (io_in_burstDone) done_cnt++;
      chk("rd_wr_excl", mem_rd & mem_wr, 0);
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_accept(input string tag, output int acyc);
    int t;
    t = 0;
    #1;
    while (io_in_wait_n !== 1'b1 && t < 400) begin
      @(negedge clock);
      #2;
      t++;
    end
    chk({tag, "_accept_timeout"}, t < 400, 1);
    acyc = cyc;
    step();
  endtask

  task automatic wait_done(input string tag, output int dcyc);
    int t;
    t = 0;
    while (io_in_burstDone !== 1'b1 && t < 400) begin
      step();
      t++;
    end
    chk({tag, "_done_timeout"}, t < 400, 1);
    dcyc = cyc;
    chk({tag, "_done_waitn"}, io_in_wait_n, 0);
    step();
    chk({tag, "_idle_waitn"}, io_in_wait_n, 1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] blen,
      input bit both, input bit chk_lat);
    int L, acyc, a0, dcyc, d0;
    logic [31:0] wa;
    L = (blen == 0) ? 1 : int'(blen);
    acc_q.delete();
    d0 = done_cnt;
    a0 = 0;
    io_in_wr = 1'b1;
    io_in_rd = both;
    io_in_addr = a;
    io_in_burstLength = blen;
    for (int k = 0; k < L; k++) begin
      io_in_din  = wd[k];
      io_in_mask = wm[k];
      wait_accept("wr", acyc);
      if (k == 0) begin
        a0 = acyc;
        io_in_addr = $urandom;
        io_in_burstLength = 8'($urandom);
      end
    end
    io_in_wr = 1'b0;
    io_in_rd = 1'b0;
    io_in_din = {$urandom, $urandom};
    wait_done("wr", dcyc);
    if (chk_lat) chk("wr_done_cycle", dcyc - a0, L + 1);
    chk("wr_naccess", acc_q.size(), L);
    for (int k = 0; k < L; k++) begin
      wa = a + 32'(8 * k);
      model_ram[wa] = merge(model_rd(wa), wd[k], wm[k]);
      if (k < acc_q.size()) begin
        chk("wr_op", {acc_q[k].rd, acc_q[k].wr}, 2'b01);
        chk("wr_addr", acc_q[k].addr, wa);
        chk("wr_din", acc_q[k].din, wd[k]);
        chk("wr_mask", acc_q[k].mask, wm[k]);
      end
      chk("wr_ram", emu_rd(wa), model_rd(wa));
    end
    chk("wr_ndone", done_cnt - d0, 1);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] blen);
    int L, acyc, dcyc, d0;
    logic [31:0] ra;
    L = (blen == 0) ? 1 : int'(blen);
    acc_q.delete();
    beat_q.delete();
    d0 = done_cnt;
    io_in_rd = 1'b1;
    io_in_addr = a;
    io_in_burstLength = blen;
    wait_accept("rd", acyc);
    io_in_rd = 1'b0;
    io_in_addr = $urandom;
    io_in_burstLength = 8'($urandom);
    wait_done("rd", dcyc);
    chk("rd_naccess", acc_q.size(), L);
    chk("rd_nbeat", beat_q.size(), L);
    for (int k = 0; k < L; k++) begin
      ra = a + 32'(8 * k);
      if (k < acc_q.size()) begin
        chk("rd_op", {acc_q[k].rd, acc_q[k].wr}, 2'b10);
        chk("rd_addr", acc_q[k].addr, ra);
      end
      if (k < beat_q.size()) begin
        chk("rd_data", beat_q[k].data, model_rd(ra));
        chk("rd_done_pos", beat_q[k].done, k == L - 1);
      end
    end
    chk("rd_ndone", done_cnt - d0, 1);
  endtask

  task automatic fill_words(input logic [7:0] m1);
    for (int k = 0; k < 16; k++) begin
      wd[k] = {$urandom, $urandom};
      wm[k] = 8'hFF;
    end
    wm[1] = m1;
  endtask

  initial begin
    int t, acyc, d0;
    logic [31:0] ra;
    logic [7:0] rl;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_waitn", io_in_wait_n, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_valid", io_in_valid, 0);
    chk("rst_done", io_in_burstDone, 0);
    chk("rst_dout", io_in_dout, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_din", mem_din, 0);
    chk("rst_mask", mem_mask, 0);
    reset = 1'b1;
    #1 chk("rel_waitn_low", io_in_wait_n, 0);
    step();
    chk("rel_waitn_high", io_in_wait_n, 1);

    lat_min = 2; lat_max = 2;
    do_read(32'h100, 8'd4);

    lat_min = 1; lat_max = 1;
    fill_words(8'h0F);
    stall_addr = 32'h208;
    stall_left = 2;
    do_write(32'h200, 8'd3, 1'b0, 1'b0);
    chk("stall_consumed", stall_left, 0);
    do_read(32'h200, 8'd3);

    fill_words(8'h3C);
    do_write(32'h300, 8'd5, 1'b0, 1'b1);

    fill_words(8'hFF);
    do_write(32'hFFFF_FFF8, 8'd0, 1'b0, 1'b1);
    do_read(32'hFFFF_FFF8, 8'd2);

    fill_words(8'hF0);
    do_write(32'h400, 8'd2, 1'b1, 1'b0);
    do_read(32'h400, 8'd2);

    lat_min = 2; lat_max = 2;
    acc_q.delete();
    beat_q.delete();
    d0 = done_cnt;
    io_in_rd = 1'b1;
    io_in_addr = 32'h500;
    io_in_burstLength = 8'd8;
    wait_accept("mid_rst", acyc);
    io_in_rd = 1'b0;
    t = 0;
    while (beat_q.size() < 2 && t < 100) begin
      step();
      t++;
    end
    chk("mid_rst_beats", beat_q.size(), 2);
    reset = 1'b0;
    #1;
    chk("mid_rst_mem_rd", mem_rd, 0);
    chk("mid_rst_valid", io_in_valid, 0);
    chk("mid_rst_dout", io_in_dout, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_waitn", io_in_wait_n, 0);
    step();
    step();
    reset = 1'b1;
    #1 chk("mid_rel_waitn_low", io_in_wait_n, 0);
    step();
    chk("mid_rel_waitn_high", io_in_wait_n, 1);
    do_read(32'h600, 8'd1);
    chk("mid_rst_no_done", done_cnt - d0, 1);

    ack_pct = 60;
    lat_min = 1; lat_max = 4;
    for (int n = 0; n < 30; n++) begin
      ra = 32'h1000 + 32'(8 * $urandom_range(15));
      rl = 8'($urandom_range(5));
      if ($urandom_range(1) == 1) begin
        fill_words(8'($urandom));
        do_write(ra, rl, 1'b0, 1'b0);
      end else begin
        do_read(ra, rl);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
